// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit serializer and the receive path.
package uart_pkg;
    localparam int   UART_DATA_W     = 8;
    localparam int   UART_FRAME_BITS = 10;
    localparam int   UART_FIFO_DEPTH = 16;
    localparam logic UART_START_LVL  = 1'b0;
    localparam logic UART_STOP_LVL   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; count carries one extra bit so full and empty differ.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally at AW bits because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter: buffers bytes in a FIFO and shifts each one out as start/8 data/stop.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH,
    parameter int MSB_FIRST    = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [7:0]                  tx_wdata,
    input  logic                        tx_wvalid,
    output logic                        tx_wready,
    input  logic                        tx_enable,
    output logic                        TX_data,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_tx_state_t         r_state;
    uart_tx_state_t         w_state_next;
    logic [BW-1:0]          r_baud;
    logic [2:0]             r_bit;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_next;
    logic [UART_DATA_W-1:0] w_fifo_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_expire;
    logic                   w_tx_next;

    function automatic logic [UART_DATA_W-1:0] shift_out(input logic [UART_DATA_W-1:0] s);
        return (MSB_FIRST != 0) ? {s[6:0], 1'b0} : {1'b0, s[7:1]};
    endfunction

    function automatic logic line_bit(input logic [UART_DATA_W-1:0] s);
        return (MSB_FIRST != 0) ? s[7] : s[0];
    endfunction

    assign tx_wready = ~w_full;
    assign w_push    = tx_wvalid & tx_wready;
    assign w_expire  = (r_baud == BAUD_LAST);
    assign tx_busy   = (r_state != IDLE);

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_wdata (tx_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_shift_next = r_shift;
        case (r_state)
            IDLE: begin
                if (!w_empty && tx_enable) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_head;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_expire) w_state_next = DATA;
            end
            DATA: begin
                if (w_expire) begin
                    w_shift_next = shift_out(r_shift);
                    if (r_bit == 3'd7) w_state_next = STOP;
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes leave with no idle gap.
                if (w_expire) begin
                    if (!w_empty && tx_enable) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_head;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        case (w_state_next)
            START:   w_tx_next = UART_START_LVL;
            DATA:    w_tx_next = line_bit(w_shift_next);
            default: w_tx_next = UART_STOP_LVL;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            TX_data <= UART_STOP_LVL;
        end else begin
            r_state <= w_state_next;
            r_baud  <= (r_state == IDLE || w_expire) ? '0 : r_baud + 1'b1;
            if (r_state != DATA)
                r_bit <= '0;
            else if (w_expire)
                r_bit <= r_bit + 1'b1;
            TX_data <= w_tx_next;
        end
    end

    always_ff @(posedge CLK) begin
        r_shift <= w_shift_next;
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two configurations, a line-decoding monitor and a byte scoreboard.
module tb_uart_tx_serializer;
    logic            CLK = 1'b0;
    logic [1:0]      rst;
    logic [1:0][7:0] wdata;
    logic [1:0]      wvalid;
    logic [1:0]      wready;
    logic [1:0]      enable;
    logic [1:0]      txd;
    logic [1:0]      busy;
    logic [1:0][4:0] cnt;

    int errors = 0;
    int checks = 0;

    byte unsigned q0[$];
    byte unsigned q1[$];

    bit          mf[2];
    int          mk[2];
    logic [39:0] ms[2];

    always #5 CLK = ~CLK;

    uart_tx_serializer #(.CLKS_PER_BIT(1), .FIFO_DEPTH(16), .MSB_FIRST(1)) u_dut0 (
        .CLK(CLK), .RST(rst[0]), .tx_wdata(wdata[0]), .tx_wvalid(wvalid[0]),
        .tx_wready(wready[0]), .tx_enable(enable[0]), .TX_data(txd[0]),
        .tx_busy(busy[0]), .fifo_count(cnt[0]));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .MSB_FIRST(0)) u_dut1 (
        .CLK(CLK), .RST(rst[1]), .tx_wdata(wdata[1]), .tx_wvalid(wvalid[1]),
        .tx_wready(wready[1]), .tx_enable(enable[1]), .TX_data(txd[1]),
        .tx_busy(busy[1]), .fifo_count(cnt[1]));

    function automatic int cpb(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic bit msbf(input int i);
        return (i == 0);
    endfunction

    // Line level of frame bit b (0 = start, 1..8 = data in wire order, 9 = stop).
    function automatic logic frame_level(input logic [7:0] d, input int b, input bit msb);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return msb ? d[8-b] : d[b-1];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic qpush(input int i, input byte unsigned d);
        if (i == 0) q0.push_back(d); else q1.push_back(d);
    endtask

    task automatic push(input int i, input byte unsigned d, input int max_wait);
        int n = 0;
        @(negedge CLK);
        wdata[i]  = d;
        wvalid[i] = 1'b1;
        while (!wready[i] && n < max_wait) begin
            @(negedge CLK);
            n++;
        end
        if (!wready[i]) begin
            chk($sformatf("push_timeout%0d", i), 32'(wready[i]), 32'd1);
            wvalid[i] = 1'b0;
            return;
        end
        qpush(i, d);
        @(posedge CLK);
        #1;
        wvalid[i] = 1'b0;
        wdata[i]  = 8'($urandom);
    endtask

    task automatic wait_idle(input int i, input int max_cyc);
        int n = 0;
        while ((cnt[i] != 0 || busy[i]) && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        chk($sformatf("drain%0d", i), 32'(cnt[i] == 0 && !busy[i]), 32'd1);
    endtask

    task automatic idle_checks(input int i, input int cycles, input int exp_cnt, input string nm);
        repeat (cycles) begin
            @(negedge CLK);
            chk({nm, "_tx"}, 32'(txd[i]), 32'd1);
            chk({nm, "_busy"}, 32'(busy[i]), 32'd0);
            chk({nm, "_cnt"}, 32'(cnt[i]), 32'(exp_cnt));
        end
    endtask

    // Receiver model: oversample the line once per cycle, then decode a whole frame at once.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                mf[i] = 1'b0;
                if (i == 0) q0.delete(); else q1.delete();
            end else if (!mf[i]) begin
                if (txd[i] == 1'b0) begin
                    mf[i] = 1'b1;
                    ms[i] = '0;
                    mk[i] = 1;
                end
            end else begin
                ms[i][mk[i]] = txd[i];
                mk[i]++;
                if (mk[i] == 10 * cpb(i)) begin
                    logic [9:0] bits;
                    logic [7:0] d;
                    bit         held;
                    int         c;
                    c    = cpb(i);
                    held = 1'b1;
                    for (int b = 0; b < 10; b++) begin
                        bits[b] = ms[i][b*c];
                        for (int s = 1; s < c; s++)
                            if (ms[i][b*c+s] !== bits[b]) held = 1'b0;
                    end
                    for (int j = 0; j < 8; j++) begin
                        if (msbf(i)) d[7-j] = bits[1+j];
                        else         d[j]   = bits[1+j];
                    end
                    chk($sformatf("bit_hold%0d", i), 32'(held), 32'd1);
                    chk($sformatf("stop_bit%0d", i), 32'(bits[9]), 32'd1);
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_byte%0d: got unexpected frame 0x%0h, expected no frame", i, d);
                    end else begin
                        byte unsigned e;
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rx_byte%0d", i), 32'(d), 32'(e));
                    end
                    mf[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [9:0] exp_a5;
        logic [7:0] pair[2];
        int         n;

        rst    = 2'b11;
        wvalid = '0;
        enable = 2'b11;
        wdata  = '0;
        repeat (3) @(posedge CLK);
        #1;
        rst = 2'b00;

        // Idle after reset.
        for (int i = 0; i < 2; i++) chk($sformatf("rst_wready%0d", i), 32'(wready[i]), 32'd1);
        idle_checks(0, 50, 0, "t1_u0");
        idle_checks(1, 10, 0, "t1_u1");

        // Single 0xA5, one clock per bit, MSB first.
        exp_a5 = 10'b0101001011;
        push(0, 8'hA5, 10);
        @(negedge CLK);
        chk("t2_latency_tx", 32'(txd[0]), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            chk($sformatf("t2_bit%0d", k), 32'(txd[0]), 32'(exp_a5[9-k]));
            chk("t2_busy", 32'(busy[0]), 32'd1);
        end
        idle_checks(0, 5, 0, "t2_after");

        // Two back-to-back frames, four clocks per bit, LSB first.
        pair[0] = 8'h3C;
        pair[1] = 8'h81;
        push(1, pair[0], 10);
        push(1, pair[1], 10);
        for (int k = 0; k < 80; k++) begin
            @(negedge CLK);
            chk($sformatf("t3_lvl%0d", k), 32'(txd[1]),
                32'(frame_level(pair[k/40], (k % 40) / 4, 1'b0)));
            chk("t3_busy", 32'(busy[1]), 32'd1);
        end
        idle_checks(1, 4, 0, "t3_after");

        // Fill with transmit disabled, hold a 17th write, then release.
        enable[0] = 1'b0;
        for (int b = 0; b < 16; b++) push(0, 8'(b), 10);
        @(negedge CLK);
        chk("t4_full_cnt", 32'(cnt[0]), 32'd16);
        chk("t4_full_wready", 32'(wready[0]), 32'd0);
        chk("t4_full_busy", 32'(busy[0]), 32'd0);
        wdata[0]  = 8'hFF;
        wvalid[0] = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            chk("t4_hold_cnt", 32'(cnt[0]), 32'd16);
            chk("t4_hold_wready", 32'(wready[0]), 32'd0);
        end
        enable[0] = 1'b1;
        @(negedge CLK);
        chk("t4_pop_wready", 32'(wready[0]), 32'd1);
        chk("t4_pop_cnt", 32'(cnt[0]), 32'd15);
        n = 0;
        while (!wready[0] && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (wready[0]) begin
            qpush(0, 8'hFF);
            @(posedge CLK);
            #1;
        end
        wvalid[0] = 1'b0;
        wait_idle(0, 400);
        idle_checks(0, 3, 0, "t4_after");

        // Reset in the middle of data bit 3 of 0x55 with a second byte queued.
        push(1, 8'h55, 10);
        push(1, 8'h66, 10);
        repeat (17) @(posedge CLK);
        #1;
        chk("t5_pre_tx", 32'(txd[1]), 32'd0);
        chk("t5_pre_busy", 32'(busy[1]), 32'd1);
        chk("t5_pre_cnt", 32'(cnt[1]), 32'd1);
        rst[1] = 1'b1;
        #1;
        chk("t5_rst_tx", 32'(txd[1]), 32'd1);
        chk("t5_rst_busy", 32'(busy[1]), 32'd0);
        chk("t5_rst_cnt", 32'(cnt[1]), 32'd0);
        chk("t5_rst_wready", 32'(wready[1]), 32'd1);
        @(posedge CLK);
        #1;
        rst[1] = 1'b0;
        idle_checks(1, 60, 0, "t5_after");

        // Disable during the first frame: it finishes, the second waits.
        push(1, 8'h01, 10);
        push(1, 8'h02, 10);
        repeat (8) @(negedge CLK);
        chk("t6_mid_busy", 32'(busy[1]), 32'd1);
        enable[1] = 1'b0;
        n = 0;
        while (busy[1] && n < 60) begin
            @(negedge CLK);
            n++;
        end
        chk("t6_frame_done", 32'(busy[1]), 32'd0);
        chk("t6_q_after_first", 32'(q1.size()), 32'd1);
        idle_checks(1, 40, 1, "t6_paused");
        enable[1] = 1'b1;
        wait_idle(1, 100);

        // Random traffic with random pauses of the transmitter.
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 30; b++) begin
                enable[i] = ($urandom_range(0, 3) != 0) || (cnt[i] >= 12);
                push(i, 8'($urandom), 200);
                repeat ($urandom_range(0, 3)) @(negedge CLK);
            end
            enable[i] = 1'b1;
            wait_idle(i, 2000);
        end

        repeat (3) @(negedge CLK);
        chk("end_q0_empty", 32'(q0.size()), 32'd0);
        chk("end_q1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
